pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the five-stage processor: one boundary between adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying an opaque DATA_W-bit payload with valid/ready handshake, hazard-unit freeze and branch flush. It supersedes the fixed PC+instruction stage register: it adds width and bubble-value parameters, an explicit valid bit, backpressure, and an optional skid buffer that registers in_ready.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_slot.sv | 38 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage payload layouts, widths and the NOP bubble.
package pipe_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     rs1_val;
    logic [31:0]     rs2_val;
    logic [31:0]     imm;
    logic [4:0]      rd;
  } id_ex_t;

  localparam int unsigned IF_ID_W = $bits(if_id_t);
  localparam int unsigned ID_EX_W = $bits(id_ex_t);

  // Bubble for an IF/ID boundary that should decode as a harmless instruction.
  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {{PC_W{1'b0}}, NOP_INSTR};

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit plus payload, with clear > load > hold priority.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W     = IF_ID_W,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // An empty slot always carries the bubble so consumers never see stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= valid_i ? data_i : BUBBLE_VAL;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with freeze/flush; define PIPE_STAGE_SKID_EN for a
// two-entry skid build whose in_ready is registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_adv;
  logic              m_load_valid;
  logic [DATA_W-1:0] m_load_data;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = m_valid & ~freeze;
  assign out_data  = m_data;
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready;
  assign m_adv     = ~freeze & (out_fire | ~m_valid);

  pipe_stage_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (m_adv),
    .valid_i (m_load_valid),
    .data_i  (m_load_data),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_load;
  logic              s_load_valid;
  logic              ready_d;
  logic              ready_q;

  // When M advances it drains S (S cannot accept then since in_ready tracks !S);
  // when M holds, any accepted payload parks in S.
  always_comb begin
    m_load_valid = s_valid | in_fire;
    m_load_data  = s_valid ? s_data : in_data;
    s_load       = m_adv ? s_valid : in_fire;
    s_load_valid = ~m_adv;
    if (flush)       ready_d = 1'b1;
    else if (s_load) ready_d = ~s_load_valid;
    else             ready_d = ~s_valid;
  end

  pipe_stage_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (s_load),
    .valid_i (s_load_valid),
    .data_i  (in_data),
    .valid_o (s_valid),
    .data_o  (s_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= ready_d;
  end

  assign in_ready  = ready_q & ~freeze;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
  always_comb begin
    m_load_valid = in_fire;
    m_load_data  = in_data;
  end

  assign in_ready  = ~rst & ~freeze & (~m_valid | out_ready);
  assign occupancy = {1'b0, m_valid};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model of the
// stage contents, directed scenarios plus randomized handshake traffic.
module tb_pipe_stage_reg;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] BUB = 64'hB0B0_0000_0000_B0B0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, freeze, flush;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic [W+3:0] exp_v;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W     (W),
    .BUBBLE_VAL (BUB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .freeze    (freeze),
    .flush     (flush),
    .occupancy (occupancy)
  );

  // Expected {in_ready, out_valid, occupancy, out_data} from the FIFO contents.
  function automatic logic [W+3:0] model_out();
    logic         rdy, vld;
    logic [W-1:0] d;
    vld = !freeze && q.size() > 0;
    d   = (q.size() > 0) ? q[0] : BUB;
    if (CAP == 2) rdy = !freeze && q.size() < 2;
    else          rdy = !freeze && (q.size() == 0 || out_ready);
    if (rst) return {1'b0, 1'b0, 2'b00, BUB};
    return {rdy, vld, 2'(q.size()), d};
  endfunction

  task automatic model_edge();
    logic [W+3:0] m;
    m = model_out();
    if (rst) q.delete();
    else if (flush) q.delete();
    else begin
      if (m[W+2] && out_ready) void'(q.pop_front());
      if (in_valid && m[W+3]) q.push_back(in_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic frz, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; freeze = frz; flush = fl;
  endtask

  task automatic test_reset();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++;
    if ({in_ready, out_valid, occupancy, out_data} !== {1'b0, 1'b0, 2'b00, BUB}) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", {in_ready, out_valid, occupancy, out_data},
               {1'b0, 1'b0, 2'b00, BUB});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    exp_v = model_out();
    checks++;
    if ({in_ready, out_valid, occupancy, out_data} !== exp_v || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {in_ready, out_valid, occupancy, out_data}, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_first();
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0, 64'h0000_0004_E3A0_1005, 1'b1, 1'b0, 1'b0);
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL first cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      if (i == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000_0004_E3A0_1005) begin
          errors++;
          $display("FAIL first_latency: got valid %b data %h want 1 0000_0004_E3A0_1005", out_valid, out_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int unsigned next_exp = 1;
    for (int i = 0; i < 10; i++) begin
      set_in(i < 8, 64'(i + 1), 1'b1, 1'b0, 1'b0);
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL stream cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'(next_exp)) begin
          errors++;
          $display("FAIL stream_order cyc %0d: got %b/%h want 1/%h", i, out_valid, out_data, 64'(next_exp));
        end
        next_exp++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] d = 64'd100;
    int unsigned  max_occ = 0;
    for (int i = 0; i < 12; i++) begin
      set_in(i < 9, d, !(i >= 3 && i <= 5), 1'b0, 1'b0);
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL stall cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      if (int'(occupancy) > max_occ) max_occ = occupancy;
      if (in_valid && in_ready) d = d + 1;
      tick();
    end
    checks++;
    if (max_occ != CAP) begin
      errors++;
      $display("FAIL stall_capacity: got %0d want %0d", max_occ, CAP);
    end
  endtask

  task automatic test_freeze();
    int unsigned seen = 0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        1:       set_in(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        2, 3:    set_in(1'b1, 64'hAA, 1'b1, 1'b1, 1'b0);
        default: set_in(1'b0, 64'hAA, 1'b1, 1'b0, 1'b0);
      endcase
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL freeze cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      if (out_valid && out_ready && out_data == 64'h55) seen++;
      tick();
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL freeze_once: got %0d deliveries want 1", seen);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1:    set_in(1'b1, 64'(i + 200), 1'b0, 1'b0, 1'b0);
        2:       set_in(1'b1, 64'hBAD, 1'b0, 1'b0, 1'b1);
        default: set_in(1'b0, 64'hBAD, 1'b1, 1'b0, 1'b0);
      endcase
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL flush cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      if (i == 3) begin
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB) begin
          errors++;
          $display("FAIL flush_empty: got %0d/%b/%h want 0/0/%h", occupancy, out_valid, out_data, BUB);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 64'h777, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 64'h778, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, occupancy, out_data} !== {1'b0, 1'b0, 2'b00, BUB}) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", {in_ready, out_valid, occupancy, out_data},
               {1'b0, 1'b0, 2'b00, BUB});
    end
    q.delete();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    exp_v = model_out();
    checks++;
    if ({in_ready, out_valid, occupancy, out_data} !== exp_v || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: got %h want %h", {in_ready, out_valid, occupancy, out_data}, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      #1;
      exp_v = model_out();
      checks++;
      if ({in_ready, out_valid, occupancy, out_data} !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, {in_ready, out_valid, occupancy, out_data}, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_stream();
    test_stall();
    test_freeze();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
